// File: rtl/cordic_pkg.sv
// Shared defaults for the CORDIC vector-mode pipeline and the scheduler tag entry.
package cordic_pkg;

  localparam int WIDTH            = 16;
  localparam int AWIDTH           = 16;
  localparam int EXTEND_PRECISION = 4;
  localparam int PIPELINE         = 15;
  localparam int PRECISION        = WIDTH + EXTEND_PRECISION;

  // Wide enough for the largest supported requester count (16).
  localparam int TAG_IDW = 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin front end sharing one Cordic vector-mode pipeline among NREQ requesters,
// with a tag shift register tracking which requester owns each in-flight sample.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int NREQ             = 4,
  parameter int WIDTH            = cordic_pkg::WIDTH,
  parameter int AWIDTH           = cordic_pkg::AWIDTH,
  parameter int EXTEND_PRECISION = cordic_pkg::EXTEND_PRECISION,
  parameter int PIPELINE         = cordic_pkg::PIPELINE,
  parameter int IDW              = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WIDTH-1:0]         req_x,
  input  logic [NREQ*WIDTH-1:0]         req_y,
  output logic                          cordic_ena,
  output logic [WIDTH-1:0]              cordic_xi,
  output logic [WIDTH-1:0]              cordic_yi,
  input  logic [WIDTH+EXTEND_PRECISION-1:0] cordic_r,
  input  logic [AWIDTH-1:0]             cordic_a,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [IDW-1:0]                res_id,
  output logic [WIDTH+EXTEND_PRECISION-1:0] res_r,
  output logic [AWIDTH-1:0]             res_a,
  output logic                          busy
);

  localparam int CW = $clog2(PIPELINE + 1);

  tag_t            tag [PIPELINE];
  tag_t            tag_in;
  logic            adv;
  logic            grant_valid;
  logic            retire;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic [CW-1:0]   count;

  // Only an unaccepted result at the last stage can hold the pipeline; bubbles never do.
  assign adv = !(tag[PIPELINE-1].valid && !res_ready);

  // Grants are suppressed while rst is high so no handshake completes in the reset cycle.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .en          (adv && !rst),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign req_ready  = grant;
  assign cordic_ena = adv;
  assign cordic_xi  = grant_valid ? req_x[grant_id*WIDTH +: WIDTH] : '0;
  assign cordic_yi  = grant_valid ? req_y[grant_id*WIDTH +: WIDTH] : '0;

  assign res_valid = tag[PIPELINE-1].valid;
  assign res_id    = tag[PIPELINE-1].id[IDW-1:0];
  assign res_r     = cordic_r;
  assign res_a     = cordic_a;
  assign retire    = res_valid && res_ready;
  assign busy      = (count != '0);

  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    tag_in                = '0;
    tag_in.valid          = grant_valid;
    tag_in.id[IDW-1:0]    = grant_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE; i++) tag[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      if (adv) begin
        tag[0] <= tag_in;
        for (int i = 1; i < PIPELINE; i++) tag[i] <= tag[i-1];
        if (grant_valid) ptr <= ptr_next;
      end
      case ({grant_valid, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Self-checking bench for cordic_scheduler: reference arbitration model, data scoreboard,
// a delay-line stand-in for the Cordic pipeline, a grant vector table and corner sequences.
module tb_cordic_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int AW   = 16;
  localparam int EP   = 4;
  localparam int P    = 15;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_x = '0;
  logic [NREQ*W-1:0]   req_y = '0;
  logic                cordic_ena;
  logic [W-1:0]        cordic_xi, cordic_yi;
  logic [W+EP-1:0]     cordic_r;
  logic [AW-1:0]       cordic_a;
  logic                res_valid;
  logic                res_ready = 1'b1;
  logic [IDW-1:0]      res_id;
  logic [W+EP-1:0]     res_r;
  logic [AW-1:0]       res_a;
  logic                busy;

  int errors = 0;
  int checks = 0;

  cordic_scheduler #(.NREQ(NREQ), .WIDTH(W), .AWIDTH(AW), .EXTEND_PRECISION(EP),
                     .PIPELINE(P), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .cordic_ena(cordic_ena), .cordic_xi(cordic_xi),
    .cordic_yi(cordic_yi), .cordic_r(cordic_r), .cordic_a(cordic_a),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_r(res_r),
    .res_a(res_a), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in pipeline: a pure delay line of PIPELINE enabled stages.
  logic [W-1:0] px [P] = '{default: '0};
  logic [W-1:0] py [P] = '{default: '0};
  always @(posedge clk) begin
    if (cordic_ena) begin
      px[0] <= cordic_xi;
      py[0] <= cordic_yi;
      for (int i = 1; i < P; i++) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end
  assign cordic_r = {{EP{1'b0}}, px[P-1]};
  assign cordic_a = py[P-1];

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: tag valids/ids, pointer, occupancy, and data scoreboard.
  typedef struct packed { logic v; logic [IDW-1:0] id; } mtag_t;
  typedef struct { logic [IDW-1:0] id; logic [W-1:0] x; logic [W-1:0] y; } sb_t;

  mtag_t          mtag [P] = '{default: '0};
  logic [IDW-1:0] mptr = '0;
  int             mcount = 0;
  sb_t            q[$];

  always @(negedge clk) begin
    logic            m_adv;
    logic            eg_any;
    int              eg_id;
    int              idx;
    logic [NREQ-1:0] exp_ready;
    logic [W-1:0]    exp_x, exp_y;
    sb_t             e;
    if (rst) begin
      chk(req_ready, '0, "rst_req_ready");
      chk(res_valid, 1'b0, "rst_res_valid");
      chk(res_id, '0, "rst_res_id");
      chk(busy, 1'b0, "rst_busy");
      chk(cordic_ena, 1'b1, "rst_cordic_ena");
      for (int i = 0; i < P; i++) mtag[i] = '0;
      mptr = '0;
      mcount = 0;
      q.delete();
    end else begin
      m_adv  = !(mtag[P-1].v && !res_ready);
      eg_any = 1'b0;
      eg_id  = 0;
      if (m_adv) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (int'(mptr) + k) % NREQ;
          if (!eg_any && req_valid[idx]) begin
            eg_any = 1'b1;
            eg_id  = idx;
          end
        end
      end
      exp_ready = eg_any ? (NREQ'(1) << eg_id) : '0;
      exp_x     = eg_any ? req_x[eg_id*W +: W] : '0;
      exp_y     = eg_any ? req_y[eg_id*W +: W] : '0;
      chk(cordic_ena, m_adv, "cordic_ena");
      chk(req_ready, exp_ready, "req_ready");
      chk(cordic_xi, exp_x, "cordic_xi");
      chk(cordic_yi, exp_y, "cordic_yi");
      chk(res_valid, mtag[P-1].v, "res_valid");
      chk(busy, mcount != 0, "busy");
      if (mtag[P-1].v) begin
        if (q.size() == 0) begin
          chk(1'b1, 1'b0, "sb_underflow");
        end else begin
          chk(res_id, q[0].id, "res_id");
          chk(res_r, {{EP{1'b0}}, q[0].x}, "res_r");
          chk(res_a, q[0].y, "res_a");
          if (res_ready) begin
            e = q.pop_front();
            mcount--;
          end
        end
      end
      if (eg_any) begin
        e.id = IDW'(eg_id);
        e.x  = exp_x;
        e.y  = exp_y;
        q.push_back(e);
        mcount++;
        mptr = IDW'((eg_id + 1) % NREQ);
      end
      if (m_adv) begin
        for (int i = P - 1; i > 0; i--) mtag[i] = mtag[i-1];
        mtag[0].v  = eg_any;
        mtag[0].id = IDW'(eg_id);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = W'($urandom);
      req_y[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct { logic [NREQ-1:0] mask; logic any; int id; } vec_t;
  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic            found;
    int              lat;
    logic [W+EP-1:0] sv_r;
    logic [AW-1:0]   sv_a;
    logic [IDW-1:0]  sv_id;
    logic [NREQ-1:0] exp;

    tbl[0]  = '{4'b1111, 1'b1, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1};
    tbl[2]  = '{4'b1111, 1'b1, 2};
    tbl[3]  = '{4'b1111, 1'b1, 3};
    tbl[4]  = '{4'b1001, 1'b1, 0};
    tbl[5]  = '{4'b1001, 1'b1, 3};
    tbl[6]  = '{4'b1001, 1'b1, 0};
    tbl[7]  = '{4'b0000, 1'b0, 0};
    tbl[8]  = '{4'b0100, 1'b1, 2};
    tbl[9]  = '{4'b0110, 1'b1, 1};
    tbl[10] = '{4'b0010, 1'b1, 1};
    tbl[11] = '{4'b1000, 1'b1, 3};

    do_reset();

    // Single accept from requester 2: result exactly PIPELINE cycles later.
    repeat (8) step();
    req_valid = 4'b0100;
    @(negedge clk);
    chk(req_ready, 4'b0100, "single_grant");
    step();
    req_valid = '0;
    found = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      chk(busy, 1'b1, "single_busy");
      if (res_valid) begin
        found = 1'b1;
        lat   = k;
      end
    end
    chk(found, 1'b1, "single_result_seen");
    chk(lat, P, "single_latency");
    chk(res_id, 2, "single_res_id");
    step();
    @(negedge clk);
    chk(busy, 1'b0, "single_busy_clear");

    // Grant table: fairness, pointer wrap, bubbles, search from pointer.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].mask;
      @(negedge clk);
      exp = tbl[i].any ? (NREQ'(1) << tbl[i].id) : '0;
      chk(req_ready, exp, $sformatf("tbl_grant_%0d", i));
      step();
    end
    req_valid = '0;
    repeat (20) step();

    // Backpressure: fill, stall five cycles, release with a simultaneous accept.
    req_valid = 4'b1111;
    repeat (P) step();
    res_ready = 1'b0;
    @(negedge clk);
    chk(res_valid, 1'b1, "bp_full_valid");
    sv_r  = res_r;
    sv_a  = res_a;
    sv_id = res_id;
    repeat (4) begin
      @(negedge clk);
      chk(cordic_ena, 1'b0, "bp_ena");
      chk(req_ready, '0, "bp_req_ready");
      chk(res_r, sv_r, "bp_hold_r");
      chk(res_a, sv_a, "bp_hold_a");
      chk(res_id, sv_id, "bp_hold_id");
    end
    step();
    res_ready = 1'b1;
    @(negedge clk);
    chk(req_ready != '0 && res_valid, 1'b1, "bp_release_both");
    step();
    req_valid = '0;
    repeat (20) step();
    chk(busy, 1'b0, "bp_drained");

    // Bubbles: alternating requests, consumer not ready on empty result slots.
    for (int i = 0; i < 32; i++) begin
      req_valid = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      res_ready = (i % 2 == 1);
      @(negedge clk);
      chk(cordic_ena, 1'b1, "bubble_ena");
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (20) step();

    // Reset with seven samples in flight.
    req_valid = 4'b1111;
    repeat (7) step();
    rst = 1'b1;
    @(negedge clk);
    chk(req_ready, '0, "rst_mid_no_grant");
    step();
    rst = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk(busy, 1'b0, "rst_mid_busy");
    chk(req_ready, 4'b0010, "rst_mid_first_grant");
    step();
    req_valid = '0;
    for (int k = 0; k < P - 2; k++) begin
      @(negedge clk);
      chk(res_valid, 1'b0, "rst_mid_no_stale");
    end
    repeat (20) step();

    chk(q.size(), 0, "sb_drained");
    chk(busy, 1'b0, "final_busy");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
# cordic_scheduler

Round-robin scheduler that shares one `Cordic` vector-mode pipeline among `NREQ` requesters. It accepts (X, Y) samples over per-requester valid/ready channels and drives the pipeline's `ena` and input ports. It tracks each in-flight sample's requester id in a tag shift register aligned with the pipeline stages. It returns each magnitude/angle result on one shared result channel with backpressure. It sits between the sensor/front-end ports and the `Cordic` instance.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `WIDTH`, 16, input sample width; must match the `Cordic` instance
- `AWIDTH`, 16, angle output width
- `EXTEND_PRECISION`, 4, guard bits; magnitude width is `WIDTH+EXTEND_PRECISION`
- `PIPELINE`, 15, `Cordic` stage count; equals its latency in enabled cycles
- `IDW`, derived = max(1, clog2(NREQ)), requester id width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester sample valid
- `req_ready`  out  NREQ  one-hot grant; the sample is accepted when valid&ready
- `req_x`  in  NREQ*WIDTH  packed X samples, requester i at [i*WIDTH +: WIDTH]
- `req_y`  in  NREQ*WIDTH  packed Y samples, same packing
- `cordic_ena`  out  1  pipeline advance enable
- `cordic_xi`, `cordic_yi`  out  WIDTH  pipeline inputs
- `cordic_r`  in  WIDTH+EXTEND_PRECISION  pipeline magnitude output
- `cordic_a`  in  AWIDTH  pipeline angle output
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts the result
- `res_id`  out  IDW  requester that owns the result
- `res_r`  out  WIDTH+EXTEND_PRECISION  magnitude, equal to `cordic_r`
- `res_a`  out  AWIDTH  angle, equal to `cordic_a`
- `busy`  out  1  at least one sample is in flight

## Operation
- **Tag register:** `PIPELINE` entries of {valid, id}. Entry 0 aligns with `Cordic` stage 1 and entry `PIPELINE-1` with the last stage.
- **Advance:** `adv = !(tag[PIPELINE-1].valid && !res_ready)`. `cordic_ena = adv`. The tag register shifts only when `adv` is high.
- **Stall cycle (`adv` low):** all `req_ready` low; round-robin pointer and tag register hold.
- **Advance cycle:** the round-robin arbiter grants the first requester with `req_valid` high, searching from `ptr` upward modulo NREQ.
  - One-hot `req_ready` is driven to that requester.
  - The granted requester's x/y go on `cordic_xi`/`cordic_yi`.
  - {1, id} shifts into tag entry 0.
  - `ptr` becomes id+1 mod NREQ.
- **No request during an advance cycle:** a bubble {0, –} shifts in, `cordic_xi`/`cordic_yi` are 0, and `ptr` is unchanged.
- **Grant path:** `req_ready` is combinational from `req_valid`, `ptr` and `adv`. Requesters must not make `req_valid` depend on `req_ready`.
- **Result channel:** `res_valid = tag[PIPELINE-1].valid`, `res_id = tag[PIPELINE-1].id`, and `res_r`/`res_a` pass straight through.
  - A bubble at the output never stalls the pipeline.
- **Occupancy counter:** width clog2(PIPELINE+1).
  - +1 on accept, –1 on result handshake.
  - Both events in the same cycle leave it unchanged.
  - `busy = (count != 0)`.
- **Input sign:** X is treated as unsigned and Y as two's complement, as `Cordic` does. The scheduler does no arithmetic on the data.
- **Reset:** asserting `rst` at any time has these effects.
  - Tag valids, `ptr` and the counter clear immediately.
  - In-flight results are discarded; pipeline data is ignored until refilled.
  - No partial handshake completes in the reset cycle.

## Timing
- **Reset values:** `req_ready` = 0, `res_valid` = 0, `res_id` = 0, `busy` = 0. `cordic_ena` = 1, because the empty pipeline can always advance.
- **Latency:** a sample accepted in cycle c with no stalls gives `res_valid` high in cycle c+`PIPELINE`. Each stall cycle adds one cycle.
- **Throughput:** one sample per cycle while `res_ready` stays high.
- **Hold under stall:** `res_valid`, `res_id`, `res_r`, `res_a` stay stable until `res_ready`.
- **Boundary cases:**
  - Full pipeline with `res_ready` low: freezes completely.
  - Release of `res_ready`: an accept and a result can both occur in that same cycle.
  - Single requester holding valid: granted every advance cycle.
  - `ptr` wrap: NREQ-1 → 0.

## Structure
- **`cordic_pkg`:** holds the default `WIDTH`, `AWIDTH`, `EXTEND_PRECISION`, `PIPELINE`, the derived `PRECISION`, and the tag entry typedef {valid, id}.
- **Sub-module `rr_arbiter`:** parameters NREQ; inputs req vector, `ptr`, enable; outputs one-hot grant and grant id. It is purely combinational.
  - The scheduler owns `ptr`, the tag register and the counter.

## Test plan
- **Single accept:** NREQ=4, PIPELINE=15, requester 2 sends one sample in cycle 10 → `res_valid` only in cycle 25, `res_id`=2, `busy` high in cycles 11..25.
- **Fairness:** all four requesters hold valid for 8 cycles with `res_ready`=1 → grants 0,1,2,3,0,1,2,3. Results return in the same id order, 15 cycles later, back-to-back.
- **Backpressure:** fill with 15 samples, then `res_ready`=0 for 5 cycles → `cordic_ena`=0, all `req_ready`=0, outputs stable. On release, the results drain in order with no loss or duplication.
- **Bubbles:** alternate one-cycle request gaps with `res_ready`=0 on empty slots → no stall, `cordic_ena` stays 1, counter equals the in-flight count.
- **Reset mid-flight:** assert `rst` with 7 samples in flight → `res_valid` never asserts for them, `busy`=0, `ptr`=0. The first post-reset request goes to the lowest valid id.
- **Pointer wrap:** only requesters 3 and 0 valid → grants alternate 3,0,3,0.
